fft_reorder_buffer: RTL and testbench
=====================================

# fft_reorder_buffer

Output-side companion of the 8-point radix-2 FFT core. The core emits one 50-bit complex bin per cycle in bit-reversed order with a 3-bit position index; this block collects each 8-bin frame and replays it in natural frequency order (bin 0..7) over a valid/ready stream. Ping-pong banks let frame N+1 be written while frame N drains. Frame-sync and overflow errors are flagged.

## Interface
- DATA_W, 50, complex word width; [49:25] signed real, [24:0] signed imag. Only 50 is supported.
- N_PTS, 8, frame length. Only 8 is supported; index width is 3.
- clk_i  in  1  clock; all logic rises on posedge.
- rst_i  in  1  reset; synchronous, active-high.
- bin_i  in  50  FFT output word.
- bin_idx_i  in  3  arrival position of bin_i in its frame, 0..7.
- bin_valid_i  in  1  bin_i/bin_idx_i valid this cycle. No backpressure to the core.
- bin_o  out  50  natural-order bin; forced to 0 when bin_valid_o=0.
- bin_num_o  out  3  frequency index k of bin_o.
- bin_valid_o  out  1  bin_o valid.
- bin_ready_i  in  1  consumer accepts; transfer = bin_valid_o & bin_ready_i.
- frame_last_o  out  1  high with bin_valid_o when bin_num_o=7.
- overflow_o  out  1  sticky: a frame was dropped because no bank was free.
- sync_err_o  out  1  sticky: bin_idx_i out of sequence.

## Operation
- Storage: two flop banks, 8x50 each, plus full[1:0], wr_bank, rd_bank, wr_cnt[2:0], rd_ptr[2:0], and a write-state register.
- Write-state FSM:
  - IDLE: waits for a valid with bin_idx_i=0 and a free wr_bank.
  - FILL: accepts the rest of the frame.
  - DROP: discards bins until the next bin_idx_i=0.
- Accepted bin: stored at bank[wr_bank][bitrev(bin_idx_i)], where bitrev maps {b2,b1,b0}->{b0,b1,b2}. wr_cnt increments.
- Frame complete: on the 8th accepted bin (wr_cnt=7), set full[wr_bank], toggle wr_bank, clear wr_cnt, go to IDLE.
- Sequence check: expected index = wr_cnt. In FILL, a valid with bin_idx_i != wr_cnt sets sync_err_o and discards the partial frame (bank stays not-full). Then:
  - bin_idx_i=0: the bin starts a new frame in the same bank.
  - otherwise: go to DROP.
  - In IDLE, a valid with bin_idx_i != 0 sets sync_err_o; the bin is ignored.
- Overflow: a valid with bin_idx_i=0 in IDLE while full[wr_bank]=1 (after same-cycle release, below) sets overflow_o, goes to DROP, and drops bins 0..7 of that frame.
- Read side:
  - bin_valid_o = full[rd_bank].
  - bin_o = bank[rd_bank][rd_ptr]; bin_num_o = rd_ptr.
  - On transfer, rd_ptr increments. At the transfer with rd_ptr=7, clear full[rd_bank], toggle rd_bank, rd_ptr wraps to 0.
- Same-cycle release and start: if the read side frees bank X in the cycle a new frame starts into bank X, release wins and the bin is accepted. No overflow.
- Write and read hit different banks and are fully concurrent.
- Bin data passes through unmodified; no arithmetic or saturation.

## Timing
- Reset: full=0, wr_bank=rd_bank=0, wr_cnt=rd_ptr=0, FSM=IDLE, overflow_o=0, sync_err_o=0. Therefore bin_o=0, bin_num_o=0, bin_valid_o=0, frame_last_o=0. Bank contents are don't-care.
- Reset mid-operation discards partial and full frames. The first valid after reset deasserts must carry index 0.
- Latency: 8th bin accepted at edge E; bin_valid_o=1 with bin_num_o=0 in the cycle after E.
- With bin_ready_i held high, a frame drains in 8 consecutive cycles.
- Sustained throughput: one bin per cycle per side, so back-to-back frames never overflow when ready is held high.
- Handshake: while bin_valid_o=1 and bin_ready_i=0, bin_o and bin_num_o hold stable. bin_valid_o never drops mid-frame.
- Sticky flags rise the cycle after the offending input and clear only on rst_i.

## Test plan
- Single frame, bit-reversed order: idx 0..7 carrying real=k,imag=-k with k=bitrev(idx), ready=1 -> 8 outputs bin_num 0..7, real 0..7, imag 0..-7; frame_last on the 8th; first output 1 cycle after the last input.
- Back-to-back frames with random ready (50%) at 1 bin/cycle -> two frames out in order, no data loss while both banks suffice. Overflow expected exactly when the third frame starts with both banks full.
- Ready held 0 after two full frames, third frame arrives -> overflow_o=1, third frame absent. Releasing ready yields frames 1 and 2 intact.
- Sequence error: idx 0,1,2,5,... -> sync_err_o=1, partial frame dropped, no output. The next idx 0..7 frame is output correctly.
- Same-cycle release: final read transfer of bank 0 coincides with idx 0 of a frame targeting bank 0 -> bin accepted, overflow_o stays 0.
- Reset asserted mid-drain (after bin 3) -> next cycle bin_valid_o=0, bin_o=0, flags 0. A subsequent full frame outputs from bin 0.

Source files
------------

// File: rtl/fft_reorder_buffer.sv
// Collects bit-reversed 8-bin FFT frames into ping-pong flop banks and replays
// each frame in natural frequency order over a valid/ready stream.
module fft_reorder_buffer #(
    parameter int DATA_W = 50,
    parameter int N_PTS  = 8,
    localparam int IDX_W = $clog2(N_PTS)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DATA_W-1:0] bin_i,
    input  logic [IDX_W-1:0]  bin_idx_i,
    input  logic              bin_valid_i,
    output logic [DATA_W-1:0] bin_o,
    output logic [IDX_W-1:0]  bin_num_o,
    output logic              bin_valid_o,
    input  logic              bin_ready_i,
    output logic              frame_last_o,
    output logic              overflow_o,
    output logic              sync_err_o
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_PTS - 1);
    localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_DROP = 2'd2
    } wr_state_t;

    function automatic logic [IDX_W-1:0] bitrev(input logic [IDX_W-1:0] idx);
        logic [IDX_W-1:0] r;
        for (int i = 0; i < IDX_W; i++) begin
            r[i] = idx[IDX_W-1-i];
        end
        return r;
    endfunction

    wr_state_t         state_q, state_d;
    logic [1:0]        full_q, full_d;
    logic              wr_bank_q, wr_bank_d;
    logic              rd_bank_q, rd_bank_d;
    logic [IDX_W-1:0]  wr_cnt_q, wr_cnt_d;
    logic [IDX_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic              overflow_q, overflow_d;
    logic              sync_err_q, sync_err_d;
    logic [DATA_W-1:0] bank_q [2][N_PTS];
    logic [DATA_W-1:0] bank_d [2][N_PTS];

    logic              transfer_s;
    logic              free_s;
    logic              idx0_s;
    logic              we_s;

    // Read-side advance, write-state FSM and bank write selection
    always_comb begin
        state_d    = state_q;
        full_d     = full_q;
        wr_bank_d  = wr_bank_q;
        rd_bank_d  = rd_bank_q;
        wr_cnt_d   = wr_cnt_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q;
        sync_err_d = sync_err_q;
        bank_d     = bank_q;
        we_s       = 1'b0;

        transfer_s = full_q[rd_bank_q] & bin_ready_i;
        if (transfer_s) begin
            rd_ptr_d = rd_ptr_q + ONE_IDX;
            if (rd_ptr_q == LAST_IDX) begin
                full_d[rd_bank_q] = 1'b0;
                rd_bank_d         = ~rd_bank_q;
            end else begin
                rd_bank_d = rd_bank_q;
            end
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        // Free check sees the release above, so a same-cycle start into the bank wins.
        free_s = ~full_d[wr_bank_q];
        idx0_s = bin_valid_i & (bin_idx_i == '0);

        case (state_q)
            S_FILL: begin
                if (bin_valid_i) begin
                    if (bin_idx_i == wr_cnt_q) begin
                        we_s = 1'b1;
                        if (wr_cnt_q == LAST_IDX) begin
                            full_d[wr_bank_q] = 1'b1;
                            wr_bank_d         = ~wr_bank_q;
                            wr_cnt_d          = '0;
                            state_d           = S_IDLE;
                        end else begin
                            wr_cnt_d = wr_cnt_q + ONE_IDX;
                        end
                    end else begin
                        sync_err_d = 1'b1;
                        if (idx0_s) begin
                            we_s     = 1'b1;
                            wr_cnt_d = ONE_IDX;
                        end else begin
                            wr_cnt_d = '0;
                            state_d  = S_DROP;
                        end
                    end
                end else begin
                    state_d = S_FILL;
                end
            end
            S_IDLE, S_DROP: begin
                if (idx0_s) begin
                    if (free_s) begin
                        we_s     = 1'b1;
                        wr_cnt_d = ONE_IDX;
                        state_d  = S_FILL;
                    end else begin
                        overflow_d = 1'b1;
                        state_d    = S_DROP;
                    end
                end else if (bin_valid_i && (state_q == S_IDLE)) begin
                    sync_err_d = 1'b1;
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d  = S_IDLE;
                wr_cnt_d = '0;
            end
        endcase

        if (we_s) begin
            bank_d[wr_bank_q][bitrev(bin_idx_i)] = bin_i;
        end else begin
            bank_d = bank_q;
        end
    end

    // Control and sticky-flag registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            full_q     <= 2'b00;
            wr_bank_q  <= 1'b0;
            rd_bank_q  <= 1'b0;
            wr_cnt_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
            sync_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            full_q     <= full_d;
            wr_bank_q  <= wr_bank_d;
            rd_bank_q  <= rd_bank_d;
            wr_cnt_q   <= wr_cnt_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
            sync_err_q <= sync_err_d;
        end
    end

    // Bank storage; contents are qualified by full_q so they need no reset
    always_ff @(posedge clk_i) begin
        bank_q <= bank_d;
    end

    // Output stream taken straight from the registered read-side state
    always_comb begin
        bin_valid_o = full_q[rd_bank_q];
        bin_num_o   = rd_ptr_q;
        overflow_o  = overflow_q;
        sync_err_o  = sync_err_q;
        if (bin_valid_o) begin
            bin_o        = bank_q[rd_bank_q][rd_ptr_q];
            frame_last_o = (rd_ptr_q == LAST_IDX);
        end else begin
            bin_o        = '0;
            frame_last_o = 1'b0;
        end
    end

endmodule

// File: tb/tb_fft_reorder_buffer.sv
// Directed and randomized bench for fft_reorder_buffer against a queue-based
// model of frame collection, bank occupancy and natural-order replay.
module tb_fft_reorder_buffer;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [49:0] bin_i;
    logic [2:0]  bin_idx_i;
    logic        bin_valid_i;
    logic [49:0] bin_o;
    logic [2:0]  bin_num_o;
    logic        bin_valid_o;
    logic        bin_ready_i;
    logic        frame_last_o;
    logic        overflow_o;
    logic        sync_err_o;

    int errors = 0;
    int checks = 0;

    // Model: output words still owed, in natural order; frames held = ceil(size/8)
    logic [49:0] q[$];
    logic [49:0] part [8];
    bit          m_fill, m_drop, m_ovf, m_sync;
    int          nexp;

    fft_reorder_buffer dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .bin_i        (bin_i),
        .bin_idx_i    (bin_idx_i),
        .bin_valid_i  (bin_valid_i),
        .bin_o        (bin_o),
        .bin_num_o    (bin_num_o),
        .bin_valid_o  (bin_valid_o),
        .bin_ready_i  (bin_ready_i),
        .frame_last_o (frame_last_o),
        .overflow_o   (overflow_o),
        .sync_err_o   (sync_err_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic int rev(input logic [2:0] i);
        int ii;
        ii = int'(i);
        return (ii % 2) * 4 + ((ii / 2) % 2) * 2 + ii / 4;
    endfunction

    function automatic logic pick_ready(input int rmode);
        if (rmode == 2) return logic'($urandom_range(0, 1));
        return (rmode == 1);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        logic        ev;
        logic [49:0] eb;
        logic [2:0]  en;
        ev = (q.size() > 0);
        eb = ev ? q[0] : 50'd0;
        en = ev ? 3'((8 - (q.size() % 8)) % 8) : 3'd0;
        check("valid", 64'(bin_valid_o), 64'(ev));
        check("bin", 64'(bin_o), 64'(eb));
        check("num", 64'(bin_num_o), 64'(en));
        check("last", 64'(frame_last_o), 64'(ev && (en == 3'd7)));
        check("overflow", 64'(overflow_o), 64'(m_ovf));
        check("sync_err", 64'(sync_err_o), 64'(m_sync));
    endtask

    task automatic model_start(input logic [49:0] d);
        if ((q.size() + 7) / 8 < 2) begin
            part[0] = d;
            nexp    = 1;
            m_fill  = 1'b1;
            m_drop  = 1'b0;
        end else begin
            m_ovf  = 1'b1;
            m_fill = 1'b0;
            m_drop = 1'b1;
        end
    endtask

    task automatic model_edge(input logic v, input logic [2:0] idx, input logic [49:0] d,
                              input logic rdy);
        logic [49:0] tmp;
        if (rdy && q.size() > 0) tmp = q.pop_front();
        if (v) begin
            if (m_fill) begin
                if (int'(idx) == nexp) begin
                    part[rev(idx)] = d;
                    nexp++;
                    if (nexp == 8) begin
                        for (int k = 0; k < 8; k++) q.push_back(part[k]);
                        m_fill = 1'b0;
                    end
                end else begin
                    m_sync = 1'b1;
                    m_fill = 1'b0;
                    if (idx == 3'd0) model_start(d);
                    else m_drop = 1'b1;
                end
            end else if (idx == 3'd0) begin
                model_start(d);
            end else if (!m_drop) begin
                m_sync = 1'b1;
            end
        end
    endtask

    // One cycle: check current outputs, drive inputs, advance model, move to next negedge
    task automatic step(input logic v, input logic [2:0] idx, input logic [49:0] d,
                        input logic rdy);
        check_outputs();
        bin_valid_i = v;
        bin_idx_i   = idx;
        bin_i       = d;
        bin_ready_i = rdy;
        model_edge(v, idx, d, rdy);
        @(negedge clk_i);
    endtask

    task automatic do_reset();
        rst_i       = 1'b1;
        bin_valid_i = 1'b0;
        bin_ready_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b0;
        q.delete();
        m_fill = 1'b0;
        m_drop = 1'b0;
        m_ovf  = 1'b0;
        m_sync = 1'b0;
        nexp   = 0;
        check("rst_valid", 64'(bin_valid_o), 64'd0);
        check("rst_bin", 64'(bin_o), 64'd0);
        check("rst_num", 64'(bin_num_o), 64'd0);
        check("rst_last", 64'(frame_last_o), 64'd0);
        check("rst_ovf", 64'(overflow_o), 64'd0);
        check("rst_sync", 64'(sync_err_o), 64'd0);
    endtask

    function automatic logic [49:0] pattern_word(input logic [2:0] idx);
        int          k;
        logic [24:0] re;
        logic [24:0] im;
        k  = rev(idx);
        re = 25'(k);
        im = 25'(-k);
        return {re, im};
    endfunction

    task automatic send_frame(input bit pat, input int rmode);
        for (int i = 0; i < 8; i++) begin
            logic [49:0] d;
            d = pat ? pattern_word(3'(i)) : 50'({$urandom(), $urandom()});
            step(1'b1, 3'(i), d, pick_ready(rmode));
        end
    endtask

    task automatic idle(input int n, input int rmode);
        for (int i = 0; i < n; i++) step(1'b0, 3'd0, 50'd0, pick_ready(rmode));
    endtask

    initial begin
        logic [24:0] ei;
        logic [2:0]  sidx;
        logic [2:0]  ridx;
        logic        rv;
        int          budget;
        rst_i       = 1'b1;
        bin_i       = 50'd0;
        bin_idx_i   = 3'd0;
        bin_valid_i = 1'b0;
        bin_ready_i = 1'b0;
        @(negedge clk_i);
        do_reset();

        // Single pattern frame: first output one cycle after the 8th input
        send_frame(1'b1, 1);
        for (int k = 0; k < 8; k++) begin
            ei = 25'(-k);
            check("t1_valid", 64'(bin_valid_o), 64'd1);
            check("t1_num", 64'(bin_num_o), 64'(k));
            check("t1_real", 64'(bin_o[49:25]), 64'(k));
            check("t1_imag", 64'(bin_o[24:0]), 64'(ei));
            check("t1_last", 64'(frame_last_o), 64'(k == 7));
            step(1'b0, 3'd0, 50'd0, 1'b1);
        end
        check("t1_done", 64'(bin_valid_o), 64'd0);

        // Back-to-back frames with random ready
        do_reset();
        send_frame(1'b0, 2);
        send_frame(1'b0, 2);
        send_frame(1'b0, 2);
        budget = 0;
        while (q.size() > 0 && budget < 200) begin
            step(1'b0, 3'd0, 50'd0, pick_ready(2));
            budget++;
        end
        check("t2_drained", 64'(bin_valid_o), 64'd0);

        // Overflow: third frame with both banks full and ready low
        do_reset();
        send_frame(1'b0, 0);
        send_frame(1'b0, 0);
        send_frame(1'b0, 0);
        check("t3_ovf", 64'(overflow_o), 64'd1);
        idle(16, 1);
        check("t3_empty", 64'(bin_valid_o), 64'd0);
        check("t3_ovf_sticky", 64'(overflow_o), 64'd1);

        // Sequence error then a clean frame
        do_reset();
        step(1'b1, 3'd0, 50'h1, 1'b1);
        step(1'b1, 3'd1, 50'h2, 1'b1);
        step(1'b1, 3'd2, 50'h3, 1'b1);
        step(1'b1, 3'd5, 50'h4, 1'b1);
        check("t4_sync", 64'(sync_err_o), 64'd1);
        step(1'b1, 3'd6, 50'h5, 1'b1);
        step(1'b1, 3'd7, 50'h6, 1'b1);
        check("t4_no_out", 64'(bin_valid_o), 64'd0);
        send_frame(1'b1, 1);
        check("t4_first", 64'(bin_o), 64'(pattern_word(3'd0)));
        idle(9, 1);

        // Same-cycle release of bank 0 and start of a frame into bank 0
        do_reset();
        send_frame(1'b0, 0);
        send_frame(1'b0, 0);
        idle(7, 1);
        check("t5_num7", 64'(bin_num_o), 64'd7);
        send_frame(1'b1, 1);
        check("t5_no_ovf", 64'(overflow_o), 64'd0);
        idle(18, 1);
        check("t5_empty", 64'(bin_valid_o), 64'd0);

        // Reset mid-drain after bin 3
        do_reset();
        send_frame(1'b1, 1);
        idle(4, 1);
        check("t6_num4", 64'(bin_num_o), 64'd4);
        do_reset();
        send_frame(1'b1, 1);
        check("t6_restart_num", 64'(bin_num_o), 64'd0);
        check("t6_restart_valid", 64'(bin_valid_o), 64'd1);
        idle(9, 1);

        // Randomized mostly-in-sequence traffic
        do_reset();
        sidx = 3'd0;
        for (int i = 0; i < 500; i++) begin
            rv   = ($urandom_range(0, 3) != 0);
            ridx = ($urandom_range(0, 29) == 0) ? 3'($urandom_range(0, 7)) : sidx;
            if (rv) sidx = ridx + 3'd1;
            step(rv, ridx, 50'({$urandom(), $urandom()}), logic'($urandom_range(0, 3) != 0));
        end
        idle(20, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
